// File: rtl/watermark_detector_if.sv
// watermark_detector_if
//   Groups the control, key and pixel-stream signals of watermark_detector.
//   master : the pixel source / controller (drives start, key, WM_select,
//            pix_valid, pix_data; observes status and results)
//   slave  : the detector itself
//   The err_cnt signal exists only when WM_DETECT_ERRCNT_EN is defined.
interface watermark_detector_if;
  logic        start;
  logic [7:0]  key;
  logic        WM_select;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        busy;
  logic        done;
  logic        detected;
  logic [15:0] match_cnt;
`ifdef WM_DETECT_ERRCNT_EN
  logic [15:0] err_cnt;

  modport master (
    output start, key, WM_select, pix_valid, pix_data,
    input  pix_ready, busy, done, detected, match_cnt, err_cnt
  );
  modport slave (
    input  start, key, WM_select, pix_valid, pix_data,
    output pix_ready, busy, done, detected, match_cnt, err_cnt
  );
`else
  modport master (
    output start, key, WM_select, pix_valid, pix_data,
    input  pix_ready, busy, done, detected, match_cnt
  );
  modport slave (
    input  start, key, WM_select, pix_valid, pix_data,
    output pix_ready, busy, done, detected, match_cnt
  );
`endif
endinterface

// File: rtl/watermark_detector.sv
// watermark_detector
//   Compares the embedded watermark bits of a pixel stream against an
//   LFSR-generated reference sequence and reports how many pixels matched.
//   One run covers NUM_PIX accepted pixels; detected is set when the final
//   match count reaches THRESH.
//
// Ports
//   clk    : clock, all state changes on its rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : watermark_detector_if.slave
//            start, key, WM_select, pix_valid, pix_data  (in)
//            pix_ready, busy, done, detected, match_cnt  (out)
//            err_cnt (out, only with WM_DETECT_ERRCNT_EN)
//
// Optional feature
//   WM_DETECT_ERRCNT_EN : adds a per-run count of mismatching pixels.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; results of the last run are held
// SEED  | load LFSR from key, latch WM_select, clear counters
// RUN   | accept pixels, compare, count; leave after pixel NUM_PIX-1
// DONE  | one-cycle done pulse, detected is updated
module watermark_detector #(
  parameter int NUM_PIX = 256,
  parameter int THRESH  = 230
) (
  input logic                 clk,
  input logic                 rst_n,
  watermark_detector_if.slave bus
);

  localparam logic [15:0] LAST_PIX = 16'(NUM_PIX - 1);
  localparam logic [15:0] THRESH_W = 16'(THRESH);

  typedef enum logic [1:0] {IDLE, SEED, RUN, DONE} state_t;

  state_t      state;
  logic [7:0]  q;
  logic        wm_sel;
  logic [15:0] pix_cnt;

  logic        accept;
  logic [1:0]  exp_bits;
  logic        match;
  logic [7:0]  q_next;

  // pix_ready is only ever high in RUN, so accept implies RUN.
  assign accept      = bus.pix_valid & bus.pix_ready;
  assign exp_bits[0] = q[0];
  assign exp_bits[1] = wm_sel ? (q[1] ^ q[0]) : 1'b0;
  assign match       = (bus.pix_data[0] == exp_bits[0]) &&
                       (!wm_sel || (bus.pix_data[1] == exp_bits[1]));
  assign q_next      = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};

`ifdef WM_DETECT_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.err_cnt <= 16'd0;
    end else if (state == SEED) begin
      bus.err_cnt <= 16'd0;
    end else if (state == RUN && accept && !match) begin
      bus.err_cnt <= bus.err_cnt + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      q             <= 8'h01;
      wm_sel        <= 1'b0;
      pix_cnt       <= 16'd0;
      bus.pix_ready <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.detected  <= 1'b0;
      bus.match_cnt <= 16'd0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= SEED;
            bus.busy <= 1'b1;
          end
        end
        SEED: begin
          // An all-zero seed would lock the LFSR, so it is replaced by 1.
          q             <= (bus.key == 8'h00) ? 8'h01 : bus.key;
          wm_sel        <= bus.WM_select;
          pix_cnt       <= 16'd0;
          bus.match_cnt <= 16'd0;
          bus.pix_ready <= 1'b1;
          state         <= RUN;
        end
        RUN: begin
          if (accept) begin
            q       <= q_next;
            pix_cnt <= pix_cnt + 16'd1;
            if (match) begin
              bus.match_cnt <= bus.match_cnt + 16'd1;
            end
            if (pix_cnt == LAST_PIX) begin
              bus.pix_ready <= 1'b0;
              bus.done      <= 1'b1;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          bus.detected <= (bus.match_cnt >= THRESH_W);
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/watermark_detector.md
WATERMARK_DETECTOR -- requirements
Module: watermark_detector

Interface
REQ-001 Parameter NUM_PIX, default 256, pixels per detection run (range 1..65535).
REQ-002 Parameter THRESH, default 230, minimum matching pixels for detected=1 (range 0..NUM_PIX).
REQ-003 clk  input  1  single clock, all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  begin a detection run (sampled in IDLE only).
REQ-006 key  input  8  watermark key (LFSR seed), sampled in SEED.
REQ-007 WM_select  input  1  1 = two embedded bits per pixel, 0 = one bit (bit 0 only), sampled in SEED.
REQ-008 pix_valid  input  1  pix_data valid this cycle.
REQ-009 pix_data  input  8  watermarked pixel; bits [1:0] carry the embedded watermark.
REQ-010 pix_ready  output  1  block accepts a pixel this cycle (high only in RUN).
REQ-011 busy  output  1  high in SEED, RUN and DONE.
REQ-012 done  output  1  one-cycle pulse at end of run.
REQ-013 detected  output  1  run result, held until next run completes or reset.
REQ-014 match_cnt  output  16  matching pixels in current or last run.

Function
REQ-015 FSM states IDLE, SEED, RUN, DONE; IDLE->SEED on start=1; SEED->RUN after one cycle; RUN->DONE on acceptance of pixel NUM_PIX-1; DONE->IDLE after one cycle.
REQ-016 SEED loads 8-bit LFSR q with key, or with 8'h01 when key==8'h00; latches WM_select; clears match_cnt and pixel counter.
REQ-017 LFSR step: q <= {q[6:0], q[7]^q[5]^q[4]^q[3]}; step occurs only on accept (pix_valid & pix_ready).
REQ-018 Expected bits from current q: exp[0]=q[0]; exp[1]=WM_select ? q[1]^q[0] : 0.
REQ-019 Pixel matches when pix_data[0]==exp[0] and, if WM_select=1, pix_data[1]==exp[1]; pix_data[7:2] ignored; with WM_select=0 pix_data[1] ignored.
REQ-020 On each accept with match, match_cnt increments by 1 in the same clock edge; no saturation needed (max NUM_PIX).
REQ-021 Pixel 0 compared against seed value; pixel i against seed stepped i times; pix_valid=0 cycles stall without advancing.
REQ-022 In DONE: done=1, detected <= (match_cnt >= THRESH) using final count including last pixel.
REQ-023 start outside IDLE ignored; start held high in IDLE after DONE begins a new run.
REQ-024 match_cnt holds its final value in IDLE until next SEED.
REQ-025 pix_valid outside RUN has no effect.

Reset
REQ-026 rst_n=0 asynchronously forces IDLE, q=8'h01, pix_ready=0, busy=0, done=0, detected=0, match_cnt=0, pixel counter=0, latched WM_select=0.
REQ-027 Reset mid-run aborts run with no done pulse; outputs at reset values on first edge after deassertion.

Configuration
REQ-028 Macro WM_DETECT_ERRCNT_EN: when defined, output err_cnt (16 bits) counts mismatching accepted pixels per run, cleared in SEED and on reset, err_cnt+match_cnt = pixels accepted.
REQ-029 Without WM_DETECT_ERRCNT_EN the err_cnt port and its counter are absent; all other behaviour identical.

Verification
REQ-030 NUM_PIX=5, key=8'h01, WM_select=1, pix_data[1:0]=11,10,00,00,11 back-to-back -> match_cnt=5, done pulse one cycle after 5th accept, detected=1 (THRESH=4).
REQ-031 Same, WM_select=0, pix_data[1:0]=11,10,00,00,11 -> bit 1 ignored, match_cnt=5; with pix_data[1:0]=00,00,00,00,00 -> match_cnt=3, detected=0 (THRESH=4), err_cnt=2 if enabled.
REQ-032 key=8'h00 -> behaves as key=8'h01 (first expected pair 11 with WM_select=1).
REQ-033 Case REQ-030 with pix_valid low on alternate cycles -> identical match_cnt and detected; LFSR does not advance on idle cycles.
REQ-034 rst_n pulsed low after pixel 2 of a run -> all outputs zero immediately, no done; new start runs cleanly to match_cnt=5.
REQ-035 start asserted during RUN -> ignored, run completes with unchanged counts.
